// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  localparam int unsigned ENTRY_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry queue of fetched {pc, instr} pairs; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         valid,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Storage, pointers and occupancy; flush has priority over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head is read straight from storage so it holds while not consumed.
  always_comb begin
    valid = (count != '0);
    head  = mem[rd_ptr];
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: BOOT/RUN FSM, fetch PC, credit-based request
// issue, response capture and the decode-side output mux.
// Optional build macro: IFETCH_BYPASS_EN (empty-queue response bypass).
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned        XLEN     = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        IMEM_AW  = 9,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            resp_kill;
  logic            resp_live;
  logic [CW:0]     credit_used;
  logic            credit_ok;

  logic            fifo_push;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_valid;
  fetch_entry_t    fifo_head;
  fetch_entry_t    resp_entry;

  logic            unused_bits;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request issue: one idle BOOT cycle, then credit-limited fetch.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN:  imem_req  = !redirect && credit_ok;
      default: state_nxt = BOOT;
    endcase
  end

  // Credit: queued entries plus the outstanding read must leave a free slot.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    credit_ok   = (credit_used < (CW+1)'(DEPTH));
  end

  // Fetch PC, request PC capture and in-flight flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  // No request is issued in a redirect cycle, so the only stale response is
  // the one landing in the redirect cycle itself; killing it there suffices.
  always_comb begin
    resp_kill  = redirect;
    resp_live  = inflight && !resp_kill;
    resp_entry = '{pc: req_pc, instr: imem_rdata};
  end

  // Output mux and queue push/pop control.
  always_comb begin
    fifo_pop  = fifo_valid && out_ready;
    fifo_push = resp_live;
    out_valid = fifo_valid;
    out_pc    = fifo_head.pc;
    out_instr = fifo_head.instr;
`ifdef IFETCH_BYPASS_EN
    if (!fifo_valid && resp_live) begin
      out_valid = 1'b1;
      out_pc    = req_pc;
      out_instr = imem_rdata;
      fifo_push = !out_ready;
    end
`endif
  end

  assign imem_addr   = fetch_pc[IMEM_AW+1:2];
  assign unused_bits = ^{redirect_pc[1:0], fetch_pc[XLEN-1:IMEM_AW+2], fetch_pc[1:0]};

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(resp_entry),
    .pop      (fifo_pop),
    .flush    (redirect),
    .count    (fifo_count),
    .valid    (fifo_valid),
    .head     (fifo_head)
  );

endmodule
